// File: rtl/pixel_batch_fifo.sv
// -----------------------------------------------------------------------------
// pixel_batch_fifo
//   Multi-batch, parallel-in / serial-out pixel buffer. A whole batch of
//   NUM_ELEMS pixels is loaded in one cycle. It is then shifted out OUT_LANES
//   pixels per dequeue. Up to NUM_BATCHES batches are held, so the next batch
//   can load while the current one drains.
//
// Ports
//   clk             in   clock
//   reset           in   async active-high reset, clears all state
//   flush           in   sync clear of contents and underflow (highest priority)
//   in_valid        in   value_in holds a batch
//   in_ready        out  a batch slot is free
//   value_in        in   batch, element i = value_in[i*ELEM_WIDTH +: ELEM_WIDTH]
//   dequeue         in   consume the current beat
//   value_out       out  current beat, lane k = element beat*OUT_LANES+k (0 when empty)
//   empty           out  no beats remain
//   almost_empty    out  1 <= beats_remaining <= ALMOST_EMPTY_BEATS
//   beats_remaining out  batch_count*BEATS - beat_idx
//   underflow       out  sticky, a dequeue was seen while empty
// -----------------------------------------------------------------------------
module pixel_batch_fifo #(
    parameter int unsigned NUM_ELEMS          = 16,
    parameter int unsigned ELEM_WIDTH         = 16,
    parameter int unsigned NUM_BATCHES        = 2,
    parameter int unsigned OUT_LANES          = 1,
    parameter int unsigned ALMOST_EMPTY_BEATS = 1,
    localparam int unsigned BEATS = NUM_ELEMS / OUT_LANES,
    localparam int unsigned CNT_W = $clog2(NUM_BATCHES * BEATS + 1),
    localparam int unsigned IN_W  = NUM_ELEMS * ELEM_WIDTH,
    localparam int unsigned OUT_W = OUT_LANES * ELEM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  value_in,
    input  logic             dequeue,
    output logic [OUT_W-1:0] value_out,
    output logic             empty,
    output logic             almost_empty,
    output logic [CNT_W-1:0] beats_remaining,
    output logic             underflow
);

    localparam int unsigned PTR_W  = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BCNT_W = $clog2(NUM_BATCHES + 1);

    // Batch storage; contents are don't-care until written, so no reset.
    logic [IN_W-1:0]   store_q [NUM_BATCHES];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BCNT_W-1:0] count_q, count_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              underflow_q, underflow_d;
    logic              empty_q, empty_d;
    logic              almost_q, almost_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [OUT_W-1:0]  value_out_q, value_out_d;

    logic              enq, deq, last_beat, pop, wr_en;
    logic [IN_W-1:0]   head_data;
    int                beat_base;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BATCHES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state computation; flags and beat data are precomputed so every
    // output comes straight from a register.
    always_comb begin
        enq         = in_valid && in_ready_q;
        deq         = dequeue && !empty_q;
        last_beat   = (beat_q == BEAT_W'(BEATS - 1));
        pop         = deq && last_beat;
        wr_en       = enq && !flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        beat_d      = beat_q;
        underflow_d = underflow_q;

        if (enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (deq) begin
            if (last_beat) begin
                beat_d   = '0;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                beat_d   = beat_q + BEAT_W'(1);
            end
        end

        if (dequeue && empty_q) begin
            underflow_d = 1'b1;
        end

        case ({enq, pop})
            2'b10:   count_d = count_q + BCNT_W'(1);
            2'b01:   count_d = count_q - BCNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            beat_d      = '0;
            underflow_d = 1'b0;
        end

        remaining_d = CNT_W'(count_d) * CNT_W'(BEATS) - CNT_W'(beat_d);
        empty_d     = (count_d == '0);
        almost_d    = !empty_d && (remaining_d <= CNT_W'(ALMOST_EMPTY_BEATS));
        in_ready_d  = (count_d != BCNT_W'(NUM_BATCHES));

        // The new head slot can only equal the slot being written when the
        // store is otherwise empty, so bypass the incoming batch in that case.
        head_data   = (wr_en && (rd_ptr_d == wr_ptr_q)) ? value_in : store_q[rd_ptr_d];
        beat_base   = int'(beat_d) * int'(OUT_W);
        value_out_d = empty_d ? '0 : head_data[beat_base +: OUT_W];
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            underflow_q <= 1'b0;
            empty_q     <= 1'b1;
            almost_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            remaining_q <= '0;
            value_out_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            underflow_q <= underflow_d;
            empty_q     <= empty_d;
            almost_q    <= almost_d;
            in_ready_q  <= in_ready_d;
            remaining_q <= remaining_d;
            value_out_q <= value_out_d;
        end
    end

    // Batch slot write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store_q[wr_ptr_q] <= value_in;
        end
    end

    assign in_ready        = in_ready_q;
    assign value_out       = value_out_q;
    assign empty           = empty_q;
    assign almost_empty    = almost_q;
    assign beats_remaining = remaining_q;
    assign underflow       = underflow_q;

endmodule

// File: tb/tb_pixel_batch_fifo.sv
// -----------------------------------------------------------------------------
// tb_pixel_batch_fifo
//   Directed bench for pixel_batch_fifo. u_dut1 is built with OUT_LANES=1 and
//   u_dut4 with OUT_LANES=4; both use 16 x 16-bit pixels and 2 batch slots.
// -----------------------------------------------------------------------------
module tb_pixel_batch_fifo;

    logic clk;
    logic reset;

    // OUT_LANES = 1 instance
    logic         flush1, iv1, deq1;
    logic [255:0] v1;
    logic         rdy1, emp1, ae1, uf1;
    logic [15:0]  vo1;
    logic [5:0]   rem1;

    // OUT_LANES = 4 instance
    logic         flush4, iv4, deq4;
    logic [255:0] v4;
    logic         rdy4, emp4, ae4, uf4;
    logic [63:0]  vo4;
    logic [3:0]   rem4;

    int n_cmp;
    int n_err;

    pixel_batch_fifo #(
        .NUM_ELEMS(16), .ELEM_WIDTH(16), .NUM_BATCHES(2),
        .OUT_LANES(1), .ALMOST_EMPTY_BEATS(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(iv1), .in_ready(rdy1), .value_in(v1),
        .dequeue(deq1), .value_out(vo1), .empty(emp1),
        .almost_empty(ae1), .beats_remaining(rem1), .underflow(uf1)
    );

    pixel_batch_fifo #(
        .NUM_ELEMS(16), .ELEM_WIDTH(16), .NUM_BATCHES(2),
        .OUT_LANES(4), .ALMOST_EMPTY_BEATS(1)
    ) u_dut4 (
        .clk(clk), .reset(reset), .flush(flush4),
        .in_valid(iv4), .in_ready(rdy4), .value_in(v4),
        .dequeue(deq4), .value_out(vo4), .empty(emp4),
        .almost_empty(ae4), .beats_remaining(rem4), .underflow(uf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk(input logic [15:0] base);
        logic [255:0] b;
        for (int i = 0; i < 16; i++) b[i*16 +: 16] = base + 16'(i);
        return b;
    endfunction

    function automatic logic [15:0] exp_order(input int j);
        logic [15:0] base;
        base = (j < 16) ? 16'hA000 : (j < 32) ? 16'hB000 : 16'hC000;
        return base + 16'(j % 16);
    endfunction

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        flush1 = 1'b0; iv1 = 1'b0; deq1 = 1'b0; v1 = '0;
        flush4 = 1'b0; iv4 = 1'b0; deq4 = 1'b0; v4 = '0;
        #2 reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Reset values
        check("rst_empty", 64'(emp1), 64'd1);
        check("rst_almost", 64'(ae1), 64'd0);
        check("rst_ready", 64'(rdy1), 64'd1);
        check("rst_rem", 64'(rem1), 64'd0);
        check("rst_uflow", 64'(uf1), 64'd0);
        check("rst_vout", 64'(vo1), 64'd0);

        // Single batch 0..15, serial drain
        v1 = mk(16'h0000); iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        check("b0_empty", 64'(emp1), 64'd0);
        check("b0_vout", 64'(vo1), 64'd0);
        check("b0_rem", 64'(rem1), 64'd16);
        check("b0_ready", 64'(rdy1), 64'd1);
        deq1 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("b0_beat", 64'(vo1), 64'(k));
        end
        check("b0_almost", 64'(ae1), 64'd1);
        check("b0_rem1", 64'(rem1), 64'd1);
        step();
        deq1 = 1'b0;
        check("b0_done_empty", 64'(emp1), 64'd1);
        check("b0_done_almost", 64'(ae1), 64'd0);
        check("b0_done_vout", 64'(vo1), 64'd0);

        // Fill both slots, hold C while full, then drain in order
        v1 = mk(16'hA000); iv1 = 1'b1;
        step();
        v1 = mk(16'hB000);
        step();
        check("full_ready", 64'(rdy1), 64'd0);
        check("full_rem", 64'(rem1), 64'd32);
        v1 = mk(16'hC000);
        step();
        check("c_blocked_ready", 64'(rdy1), 64'd0);
        check("c_blocked_rem", 64'(rem1), 64'd32);
        deq1 = 1'b1;
        for (int j = 0; j < 48; j++) begin
            check("order", 64'(vo1), 64'(exp_order(j)));
            step();
            if (j == 15) begin
                check("a_drained_ready", 64'(rdy1), 64'd1);
                check("a_drained_rem", 64'(rem1), 64'd16);
            end
            if (j == 16) begin
                iv1 = 1'b0;
                check("c_accept_rem", 64'(rem1), 64'd31);
                check("c_accept_ready", 64'(rdy1), 64'd0);
            end
        end
        deq1 = 1'b0;
        check("order_end_empty", 64'(emp1), 64'd1);

        // Last-beat dequeue together with an enqueue
        v1 = mk(16'hD000); iv1 = 1'b1;
        step();
        iv1 = 1'b0; deq1 = 1'b1;
        repeat (15) step();
        check("d_last_vout", 64'(vo1), 64'h000000000000D00F);
        v1 = mk(16'hE000); iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        check("sim_rem", 64'(rem1), 64'd16);
        check("sim_vout", 64'(vo1), 64'h000000000000E000);
        check("sim_ready", 64'(rdy1), 64'd1);
        check("sim_almost", 64'(ae1), 64'd0);
        for (int j = 0; j < 16; j++) begin
            check("sim_drain", 64'(vo1), 64'(16'hE000 + 16'(j)));
            step();
        end
        deq1 = 1'b0;
        check("sim_end_empty", 64'(emp1), 64'd1);

        // Underflow is sticky until flush
        deq1 = 1'b1;
        step();
        deq1 = 1'b0;
        check("uf_set", 64'(uf1), 64'd1);
        check("uf_empty", 64'(emp1), 64'd1);
        check("uf_rem", 64'(rem1), 64'd0);
        v1 = mk(16'hA000); iv1 = 1'b1;
        step();
        iv1 = 1'b0; deq1 = 1'b1;
        repeat (2) step();
        deq1 = 1'b0;
        check("uf_sticky", 64'(uf1), 64'd1);
        check("uf_traffic_rem", 64'(rem1), 64'd14);
        flush1 = 1'b1; iv1 = 1'b1; v1 = mk(16'h7000);
        step();
        flush1 = 1'b0; iv1 = 1'b0;
        check("fl_uflow", 64'(uf1), 64'd0);
        check("fl_empty", 64'(emp1), 64'd1);
        check("fl_ready", 64'(rdy1), 64'd1);
        check("fl_rem", 64'(rem1), 64'd0);
        check("fl_vout", 64'(vo1), 64'd0);
        step();
        check("fl_no_enq", 64'(emp1), 64'd1);

        // Asynchronous reset in the middle of a drain
        v1 = mk(16'h5000); iv1 = 1'b1;
        step();
        iv1 = 1'b0; deq1 = 1'b1;
        repeat (7) step();
        deq1 = 1'b0;
        check("ar_pre_vout", 64'(vo1), 64'h0000000000005007);
        #2 reset = 1'b1;
        #1;
        check("ar_empty", 64'(emp1), 64'd1);
        check("ar_vout", 64'(vo1), 64'd0);
        check("ar_rem", 64'(rem1), 64'd0);
        #1 reset = 1'b0;
        v1 = mk(16'h6000); iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        check("ar_new_vout", 64'(vo1), 64'h0000000000006000);
        check("ar_new_rem", 64'(rem1), 64'd16);

        // Four-lane beats
        v4 = mk(16'h0000); iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        check("l4_rem", 64'(rem4), 64'd4);
        check("l4_beat0", vo4, 64'h0003_0002_0001_0000);
        deq4 = 1'b1;
        step();
        check("l4_beat1", vo4, 64'h0007_0006_0005_0004);
        step();
        check("l4_beat2", vo4, 64'h000B_000A_0009_0008);
        step();
        check("l4_beat3", vo4, 64'h000F_000E_000D_000C);
        check("l4_almost", 64'(ae4), 64'd1);
        step();
        deq4 = 1'b0;
        check("l4_empty", 64'(emp4), 64'd1);
        check("l4_vout0", vo4, 64'd0);
        check("l4_uflow", 64'(uf4), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
